// File: rtl/asphalt_keycode_pkg.sv
// Shared constants for the keycode input port: register map, bit positions,
// keycode width and default FIFO depth.
package asphalt_keycode_pkg;

  localparam int unsigned KEY_W         = 8;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Avalon-MM word addresses
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_IRQ_EN  = 2'd2,
    REG_CONTROL = 2'd3
  } reg_addr_e;

  // DATA register layout
  localparam int unsigned DATA_VALID_BIT    = 8;

  // STATUS register layout
  localparam int unsigned STATUS_COUNT_W    = 7;
  localparam int unsigned STATUS_FULL_BIT   = 8;
  localparam int unsigned STATUS_OVF_BIT    = 9;

  // CONTROL / IRQ_EN register layout
  localparam int unsigned CONTROL_FLUSH_BIT = 0;
  localparam int unsigned IRQ_EN_BIT        = 0;

  // Assemble the STATUS read word from its fields
  function automatic logic [31:0] status_word(input logic [STATUS_COUNT_W-1:0] count,
                                              input logic full,
                                              input logic ovf);
    logic [31:0] w;
    w = '0;
    w[STATUS_COUNT_W-1:0] = count;
    w[STATUS_FULL_BIT]    = full;
    w[STATUS_OVF_BIT]     = ovf;
    return w;
  endfunction

  // Assemble the DATA read word from its fields
  function automatic logic [31:0] data_word(input logic valid,
                                            input logic [KEY_W-1:0] code);
    logic [31:0] w;
    w = '0;
    w[KEY_W-1:0]      = code;
    w[DATA_VALID_BIT] = valid;
    return w;
  endfunction

endpackage

// File: rtl/asphalt_keycode_fifo.sv
// Keycode FIFO: storage array plus read/write pointers and occupancy count.
// Push is accepted when not full or when a pop frees a slot in the same cycle;
// flush wins over both push and pop.
module asphalt_keycode_fifo
  import asphalt_keycode_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = KEY_W,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_COUNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop & ~flush & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and count update; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents are left as-is on reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/asphalt_keycode_in.sv
// Avalon-MM keyboard keycode input port: buffers decoder keycodes in a FIFO
// and exposes DATA / STATUS / IRQ_EN / CONTROL registers.
// Optional interrupt enable register and irq output: define ASPHALT_KEYCODE_IN_IRQ_EN.
module asphalt_keycode_in
  import asphalt_keycode_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic             rd_strobe;
  logic             wr_strobe;
  logic             pop_req;
  logic             flush_req;
  logic             ovf_event;
  logic             ovf_clear;
  logic             overflow;
  logic             irq_en_q;
  logic [KEY_W-1:0] fifo_dout;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [STATUS_COUNT_W-1:0] count_ext;
  logic             unused_wdata;

  assign rd_strobe = chipselect & ~read_n;
  assign wr_strobe = chipselect & ~write_n;
  assign pop_req   = rd_strobe & (address == REG_DATA) & ~fifo_empty;
  assign flush_req = wr_strobe & (address == REG_CONTROL) & writedata[CONTROL_FLUSH_BIT];
  // A full FIFO drops the keycode unless a pop makes room; a flush drops it silently
  assign ovf_event = key_valid & fifo_full & ~pop_req & ~flush_req;
  assign ovf_clear = wr_strobe & (address == REG_STATUS) & writedata[STATUS_OVF_BIT];
  assign count_ext = STATUS_COUNT_W'(fifo_count);
  assign unused_wdata = ^{writedata[31:10], writedata[8:1]};

  asphalt_keycode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (key_valid),
    .pop   (pop_req),
    .flush (flush_req),
    .din   (key_code),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow flag; a new overflow in the clearing cycle keeps it set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (ovf_event) overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

`ifdef ASPHALT_KEYCODE_IN_IRQ_EN
  // Interrupt enable register and registered level interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_strobe && (address == REG_IRQ_EN)) irq_en_q <= writedata[IRQ_EN_BIT];
      irq <= irq_en_q & (~fifo_empty | overflow);
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  // Register read mux, combinational from address and current state
  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      REG_DATA:    readdata = data_word(~fifo_empty, fifo_dout);
      REG_STATUS:  readdata = status_word(count_ext, fifo_full, overflow);
      REG_IRQ_EN:  readdata[IRQ_EN_BIT] = irq_en_q;
      REG_CONTROL: readdata = '0;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_asphalt_keycode_in.sv
// Directed bench for asphalt_keycode_in (DEPTH=8): vector table plus
// hand-written flush, irq and asynchronous reset sequences.
module tb_asphalt_keycode_in;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        irq;

  int unsigned n_pass;
  int unsigned n_checks;

  typedef struct {
    logic        kv;
    logic [7:0]  kc;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  asphalt_keycode_in #(.DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic kv, logic [7:0] kc, logic rd, logic wr,
                              logic [1:0] a, logic [31:0] wd, logic [31:0] e);
    vec_t v;
    v.kv = kv; v.kc = kc; v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.exp_rd = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
  endtask

  // Drive one cycle of inputs after the falling edge, then check readdata before the rising edge
  task automatic apply(input vec_t x, input string nm);
    @(negedge clk);
    key_valid  = x.kv;
    key_code   = x.kc;
    chipselect = x.rd | x.wr;
    read_n     = ~x.rd;
    write_n    = ~x.wr;
    address    = x.addr;
    writedata  = x.wd;
    #2;
    check(nm, readdata, x.exp_rd);
  endtask

  logic exp_irq_on;

  initial begin
    n_pass = 0;
    n_checks = 0;
`ifdef ASPHALT_KEYCODE_IN_IRQ_EN
    exp_irq_on = 1'b1;
`else
    exp_irq_on = 1'b0;
`endif

    // Basic push/pop of two codes
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h000));
    tbl.push_back(mk(1, 8'h1C, 1, 0, 2'd1, 0, 32'h000));
    tbl.push_back(mk(1, 8'h32, 1, 0, 2'd1, 0, 32'h001));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h002));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h11C));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h132));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h000));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h000));
    // Keycode 0x00 is still a push
    tbl.push_back(mk(1, 8'h00, 0, 0, 2'd1, 0, 32'h000));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h100));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h000));
    // Nine pushes into depth 8: ninth dropped, overflow set
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk(1, 8'(i), 1, 0, 2'd1, 0, 32'(i-1) | ((i == 9) ? 32'h100 : 32'h0)));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h308));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h100 | 32'(i)));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h200));
    tbl.push_back(mk(0, 8'h00, 0, 1, 2'd1, 32'h200, 32'h200));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h000));
    // Full FIFO: push concurrent with pop keeps count 8, no overflow
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'h10 + 8'(i), 1, 0, 2'd1, 0, 32'(i)));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h108));
    tbl.push_back(mk(1, 8'h55, 1, 0, 2'd0, 0, 32'h110));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h108));
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h110 + 32'(i)));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h155));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h000));
    // Overflow clear racing a new overflow, then flush while full with key_valid
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'h20 + 8'(i), 1, 0, 2'd1, 0, 32'(i)));
    tbl.push_back(mk(1, 8'h99, 1, 0, 2'd1, 0, 32'h108));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h308));
    tbl.push_back(mk(1, 8'h98, 0, 1, 2'd1, 32'h200, 32'h308));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h308));
    tbl.push_back(mk(0, 8'h00, 0, 1, 2'd1, 32'h200, 32'h308));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h108));
    tbl.push_back(mk(1, 8'h97, 0, 1, 2'd3, 32'h1, 32'h000));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h000));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h000));

    // Reset state
    reset = 1'b1; key_valid = 1'b0; key_code = '0; chipselect = 1'b0;
    read_n = 1'b1; write_n = 1'b1; writedata = '0; address = 2'd1;
    #1;
    check("reset_status", readdata, 32'h0);
    address = 2'd0;
    #1;
    check("reset_data", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec[%0d]", i));

    // Flush with three codes buffered and a same-cycle keycode
    apply(mk(1, 8'h61, 1, 0, 2'd1, 0, 32'h0), "flush_fill0");
    apply(mk(1, 8'h62, 1, 0, 2'd1, 0, 32'h1), "flush_fill1");
    apply(mk(1, 8'h63, 1, 0, 2'd1, 0, 32'h2), "flush_fill2");
    apply(mk(1, 8'h77, 0, 1, 2'd3, 32'h1, 32'h0), "flush_ctl");
    apply(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h0), "flush_status");
    apply(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h0), "flush_data");

    // Interrupt enable and irq level
    apply(mk(0, 8'h00, 0, 1, 2'd2, 32'h1, 32'h0), "irqen_write");
    apply(mk(0, 8'h00, 1, 0, 2'd2, 0, {31'b0, exp_irq_on}), "irqen_read");
    check("irq_idle", {31'b0, irq}, 32'h0);
    apply(mk(1, 8'h2A, 1, 0, 2'd1, 0, 32'h0), "irq_push");
    apply(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h1), "irq_wait0");
    apply(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h1), "irq_wait1");
    check("irq_high", {31'b0, irq}, {31'b0, exp_irq_on});
    apply(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h12A), "irq_pop");
    apply(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h0), "irq_wait2");
    apply(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h0), "irq_wait3");
    check("irq_low", {31'b0, irq}, 32'h0);

    // Asynchronous reset with five codes buffered
    for (int i = 0; i < 5; i++)
      apply(mk(1, 8'h31 + 8'(i), 1, 0, 2'd1, 0, 32'(i)), $sformatf("ar_fill%0d", i));
    apply(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h5), "ar_pre_status");
    check("ar_pre_irq", {31'b0, irq}, {31'b0, exp_irq_on});
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("ar_status", readdata, 32'h0);
    check("ar_irq", {31'b0, irq}, 32'h0);
    address = 2'd0;
    #1;
    check("ar_data", readdata, 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    apply(mk(1, 8'h41, 1, 0, 2'd1, 0, 32'h0), "post_push0");
    apply(mk(1, 8'h42, 1, 0, 2'd1, 0, 32'h1), "post_push1");
    apply(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h141), "post_pop0");
    apply(mk(0, 8'h00, 1, 0, 2'd0, 0, 32'h142), "post_pop1");
    apply(mk(0, 8'h00, 1, 0, 2'd1, 0, 32'h0), "post_status");
    apply(mk(0, 8'h00, 1, 0, 2'd2, 0, 32'h0), "post_irqen");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
